// File: rtl/thermostat_pkg.sv
// Shared constants, sampler FSM states and the output saturation helper
// for the thermostat controller datapath.
package thermostat_pkg;

  localparam int C_TEMP_W     = 9;
  localparam int C_SPI_TEMP_W = 10;
  localparam int C_CONV_W     = 14;
  localparam int C_F_OFFSET_Q = 128;
  localparam int C_TEMP_MAX_Q = 511;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_CAPTURE  = 3'd2,
    S_WAIT_LOW = 3'd3,
    S_DROP     = 3'd4
  } t_sampler_state;

  function automatic logic [C_TEMP_W-1:0] sat_q(input logic [C_CONV_W-1:0] v);
    if (v > C_CONV_W'(C_TEMP_MAX_Q)) begin
      return C_TEMP_W'(C_TEMP_MAX_Q);
    end else begin
      return v[C_TEMP_W-1:0];
    end
  endfunction

endpackage

// File: rtl/temp_q_convert.sv
// Quarter-degree Celsius to ufixed [6:-2] output: clamps negatives to zero,
// optionally converts to Fahrenheit, saturates at full scale.
module temp_q_convert
  import thermostat_pkg::*;
(
  input  logic signed [C_SPI_TEMP_W-1:0] i_q,
  input  logic                           i_use_f,
  output logic [C_TEMP_W-1:0]            o_temp
);

  logic [C_CONV_W-1:0] mag_s;
  logic [C_CONV_W-1:0] f_s;

  always_comb begin
    if (i_q[C_SPI_TEMP_W-1]) begin
      mag_s = 14'd0;
    end else begin
      mag_s = {4'd0, i_q};
    end
    // F in quarter degrees: 9/5 scale plus 32 F (128 quarters)
    f_s = (mag_s * 14'd9) / 14'd5 + C_CONV_W'(C_F_OFFSET_Q);
    if (i_use_f) begin
      o_temp = sat_q(f_s);
    end else begin
      o_temp = sat_q(mag_s);
    end
  end

endmodule

// File: rtl/temp_sampler.sv
// Periodic thermometer sampler feeding the thermostat controller.
// Define TEMP_SAMPLER_AVG_EN to enable the 4-sample moving average.
module temp_sampler
  import thermostat_pkg::*;
#(
  parameter int g_sample_period = 10000,
  parameter int g_ready_timeout = 4000
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_use_f,
  output logic                    o_read_therm,
  input  logic                    i_therm_ready,
  input  logic [C_SPI_TEMP_W-1:0] i_spi_temperature,
  output logic [C_TEMP_W-1:0]     o_temperature,
  output logic                    o_temp_valid,
  output logic                    o_therm_fault
);

  localparam int C_PER_W = (g_sample_period > 1) ? $clog2(g_sample_period) : 1;
  localparam int C_TMO_W = (g_ready_timeout > 1) ? $clog2(g_ready_timeout) : 1;
  localparam logic [C_PER_W-1:0] C_PER_LAST = C_PER_W'(g_sample_period - 1);
  localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(g_ready_timeout - 1);

  t_sampler_state                  state_q, state_d;
  logic [C_PER_W-1:0]              per_cnt_q, per_cnt_d;
  logic [C_TMO_W-1:0]              tmo_cnt_q, tmo_cnt_d;
  logic signed [C_SPI_TEMP_W-1:0]  cap_q, cap_d;
  logic signed [C_SPI_TEMP_W-1:0]  filt_q, filt_d;
  logic                            upd_q, upd_d;
  logic                            read_q, read_d;
  logic [C_TEMP_W-1:0]             temp_q, temp_d;
  logic                            valid_q, valid_d;
  logic                            fault_q, fault_d;
  logic                            tick_s;
  logic signed [C_SPI_TEMP_W-1:0]  filt_s;
  logic [C_TEMP_W-1:0]             conv_s;

`ifdef TEMP_SAMPLER_AVG_EN
  logic signed [C_SPI_TEMP_W-1:0]  hist_q [4];
  logic signed [C_SPI_TEMP_W-1:0]  hist_d [4];
  logic                            primed_q, primed_d;
  logic signed [11:0]              sum_s;
  logic signed [11:0]              avg_s;

  // Moving-average history; the first capture after reset primes every slot
  always_comb begin
    hist_d   = hist_q;
    primed_d = primed_q;
    if (state_q == S_CAPTURE) begin
      primed_d = 1'b1;
      if (primed_q) begin
        hist_d[0] = cap_q;
        hist_d[1] = hist_q[0];
        hist_d[2] = hist_q[1];
        hist_d[3] = hist_q[2];
      end else begin
        for (int i = 0; i < 4; i++) begin
          hist_d[i] = cap_q;
        end
      end
    end else begin
      primed_d = primed_q;
    end
    sum_s = {{2{hist_d[0][9]}}, hist_d[0]} + {{2{hist_d[1][9]}}, hist_d[1]}
          + {{2{hist_d[2][9]}}, hist_d[2]} + {{2{hist_d[3][9]}}, hist_d[3]};
    avg_s  = sum_s >>> 2;
    filt_s = avg_s[C_SPI_TEMP_W-1:0];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= '0;
      end
      primed_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      primed_q <= primed_d;
    end
  end
`else
  assign filt_s = cap_q;
`endif

  temp_q_convert u_convert (
    .i_q     (filt_q),
    .i_use_f (i_use_f),
    .o_temp  (conv_s)
  );

  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    cap_d     = cap_q;
    filt_d    = filt_q;
    upd_d     = 1'b0;
    read_d    = read_q;
    temp_d    = temp_q;
    valid_d   = valid_q;
    fault_d   = fault_q;

    tick_s = (per_cnt_q == C_PER_LAST);
    if (tick_s) begin
      per_cnt_d = '0;
    end else begin
      per_cnt_d = per_cnt_q + C_PER_W'(1);
    end

    // Output register loads one cycle after the filter stage
    if (upd_q) begin
      temp_d  = conv_s;
      valid_d = 1'b1;
    end else begin
      temp_d  = temp_q;
    end

    case (state_q)
      S_IDLE: begin
        if (tick_s) begin
          state_d   = S_REQ;
          read_d    = 1'b1;
          tmo_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (i_therm_ready) begin
          cap_d   = i_spi_temperature;
          read_d  = 1'b0;
          state_d = S_CAPTURE;
        end else if (tmo_cnt_q == C_TMO_LAST) begin
          fault_d = 1'b1;
          read_d  = 1'b0;
          state_d = S_DROP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + C_TMO_W'(1);
        end
      end
      S_CAPTURE: begin
        fault_d = 1'b0;
        filt_d  = filt_s;
        upd_d   = 1'b1;
        read_d  = 1'b0;
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        read_d = 1'b0;
        if (!i_therm_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_LOW;
        end
      end
      S_DROP: begin
        read_d  = 1'b0;
        state_d = S_WAIT_LOW;
      end
      default: begin
        read_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      per_cnt_q <= C_PER_LAST;
      tmo_cnt_q <= '0;
      cap_q     <= '0;
      filt_q    <= '0;
      upd_q     <= 1'b0;
      read_q    <= 1'b0;
      temp_q    <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      cap_q     <= cap_d;
      filt_q    <= filt_d;
      upd_q     <= upd_d;
      read_q    <= read_d;
      temp_q    <= temp_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
    end
  end

  assign o_read_therm  = read_q;
  assign o_temperature = temp_q;
  assign o_temp_valid  = valid_q;
  assign o_therm_fault = fault_q;

endmodule

// File: tb/tb_temp_sampler.sv
// Self-checking bench for temp_sampler: directed vector table, corner
// sequences and randomized samples against a behavioural model.
`timescale 1ns/1ps
module tb_temp_sampler;

  localparam int PERIOD = 48;
  localparam int TMO    = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       use_f = 1'b0;
  logic       ready = 1'b0;
  logic [9:0] spi = 10'd0;
  logic       read_therm;
  logic [8:0] temp;
  logic       valid;
  logic       fault;

  temp_sampler #(.g_sample_period(PERIOD), .g_ready_timeout(TMO)) dut (
    .i_clk             (clk),
    .i_reset_n         (rst_n),
    .i_use_f           (use_f),
    .o_read_therm      (read_therm),
    .i_therm_ready     (ready),
    .i_spi_temperature (spi),
    .o_temperature     (temp),
    .o_temp_valid      (valid),
    .o_therm_fault     (fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // behavioural model state
  int exp_temp  = 0;
  int exp_valid = 0;
  int hist[$];
  int last_rise = -1;
  int rel_cyc   = -1;

  typedef struct {
    bit         f;
    logic [9:0] v;
    int         delay;
    bit         stale;
    logic [8:0] exp_t;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  function automatic int ref_conv(input int q, input bit f);
    int c;
    c = (q < 0) ? 0 : q;
    if (f) c = (c * 9) / 5 + 128;
    return (c > 511) ? 511 : c;
  endfunction

  task automatic model_capture(input int raw, input bit f);
    int s;
    int sum;
    int m;
    int q;
    s = (raw >= 512) ? raw - 1024 : raw;
`ifdef TEMP_SAMPLER_AVG_EN
    if (hist.size() == 0) begin
      for (int i = 0; i < 4; i++) hist.push_back(s);
    end else begin
      hist.push_back(s);
      void'(hist.pop_front());
    end
    sum = 0;
    foreach (hist[i]) sum += hist[i];
    m = sum % 4;
    if (m < 0) m += 4;
    q = (sum - m) / 4;
`else
    sum = s;
    m = 0;
    q = sum - m;
`endif
    exp_temp  = ref_conv(q, f);
    exp_valid = 1;
  endtask

  task automatic model_reset();
    hist.delete();
    exp_temp  = 0;
    exp_valid = 0;
    last_rise = -1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (read_therm) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("req_wait_expired", 0, 1);
    end else if (rel_cyc >= 0) begin
      chk("first_req_after_release", cyc - rel_cyc, 1);
      rel_cyc = -1;
      last_rise = cyc;
    end else begin
      if (last_rise >= 0) chk("req_period", cyc - last_rise, PERIOD);
      last_rise = cyc;
    end
  endtask

  task automatic do_sample(input bit f, input int v, input int delay, input bit stale,
                           input bit has_exp, input int exp_c);
    bit ok;
    int old_t;
    int old_v;
    use_f = f;
    if (stale) begin
      repeat (3) @(negedge clk);
      ready = 1'b1;
      spi   = v[9:0];
    end
    wait_req(ok);
    if (!ok) begin
      ready = 1'b0;
      return;
    end
    if (!stale) begin
      repeat (delay) @(negedge clk);
      chk("read_held_until_ready", read_therm, 1);
      ready = 1'b1;
      spi   = v[9:0];
    end
    old_t = exp_temp;
    old_v = exp_valid;
    model_capture(v, f);
    @(negedge clk);
    chk("read_low_after_ready", read_therm, 0);
    @(negedge clk);
    chk("temp_not_early", temp, old_t);
    chk("valid_not_early", valid, old_v);
    @(negedge clk);
    chk("temp_model", temp, exp_temp);
    if (has_exp) chk("temp_table", temp, exp_c);
    chk("valid_after_capture", valid, 1);
    chk("fault_clear_after_capture", fault, 0);
    ready = 1'b0;
  endtask

  task automatic do_timeout();
    bit ok;
    int cnt;
    wait_req(ok);
    if (!ok) return;
    cnt = 1;
    for (int i = 0; i < 4 * TMO; i++) begin
      @(negedge clk);
      if (!read_therm) break;
      cnt++;
    end
    chk("timeout_high_clocks", cnt, TMO);
    chk("fault_after_timeout", fault, 1);
    chk("temp_held_in_fault", temp, exp_temp);
    chk("valid_held_in_fault", valid, exp_valid);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef TEMP_SAMPLER_AVG_EN
    tbl.push_back('{1'b0, 10'h064, 2, 1'b0, 9'h064});
    tbl.push_back('{1'b0, 10'h068, 0, 1'b0, 9'h065});
    tbl.push_back('{1'b0, 10'h06C, 3, 1'b1, 9'h067});
    tbl.push_back('{1'b0, 10'h070, 1, 1'b0, 9'h06A});
    tbl.push_back('{1'b1, 10'h070, 4, 1'b0, 9'h144});
`else
    tbl.push_back('{1'b0, 10'h064, 2, 1'b0, 9'h064});
    tbl.push_back('{1'b1, 10'h064, 0, 1'b0, 9'h134});
    tbl.push_back('{1'b1, 10'h190, 5, 1'b0, 9'h1FF});
    tbl.push_back('{1'b0, 10'h190, 1, 1'b1, 9'h190});
    tbl.push_back('{1'b0, 10'h3EC, 3, 1'b0, 9'h000});
    tbl.push_back('{1'b1, 10'h3EC, 0, 1'b1, 9'h080});
    tbl.push_back('{1'b0, 10'h1FF, 4, 1'b0, 9'h1FF});
    tbl.push_back('{1'b1, 10'd5,   2, 1'b0, 9'h089});
    tbl.push_back('{1'b1, 10'd7,   1, 1'b0, 9'h08C});
    tbl.push_back('{1'b0, 10'h200, 0, 1'b0, 9'h000});
`endif

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_read", read_therm, 0);
    chk("reset_temp", temp, 0);
    chk("reset_valid", valid, 0);
    chk("reset_fault", fault, 0);
    model_reset();
    rst_n   = 1'b1;
    rel_cyc = cyc;

    foreach (tbl[i]) begin
      do_sample(tbl[i].f, int'(tbl[i].v), tbl[i].delay, tbl[i].stale, 1'b1, int'(tbl[i].exp_t));
    end

    // use_f change alone must not touch the registered output
    do_sample(1'b0, 10'h064, 1, 1'b0, 1'b0, 0);
    use_f = 1'b1;
    repeat (10) @(negedge clk);
    chk("use_f_no_recompute", temp, exp_temp);

    // timeout, then a good sample clears the fault
    do_timeout();
    do_sample(1'b0, 10'h0A0, 2, 1'b0, 1'b0, 0);
    chk("fault_cleared_by_good", fault, 0);

    // asynchronous reset in the middle of a request
    begin
      bit ok;
      wait_req(ok);
      chk("read_high_before_reset", read_therm, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("reset_async_read", read_therm, 0);
      chk("reset_async_temp", temp, 0);
      chk("reset_async_valid", valid, 0);
      chk("reset_async_fault", fault, 0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
      rel_cyc = cyc;
    end
    do_sample(1'b1, 10'h064, 0, 1'b0, 1'b0, 0);

    // randomized samples with occasional timeouts
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        do_timeout();
      end else begin
        do_sample(1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
                  int'($urandom_range(0, 8)), ($urandom_range(0, 3) == 0), 1'b0, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
